// File: rtl/scoreboard_scan_driver.sv
// N-player BCD scorekeeper with a time-multiplexed common-anode 7-segment scan driver.
// Scores saturate at all nines; the match winner's digits blink once game_over is set.
module scoreboard_scan_driver #(
    parameter int PLAYERS      = 2,
    parameter int DIGITS       = 2,
    parameter int WIN_SCORE    = 11,
    parameter int DWELL        = 1,
    parameter int BLINK_CYCLES = 256,
    parameter int BLANK_LZ     = 1
) (
    input  logic                                          clkouts,
    input  logic                                          resetb,
    input  logic [PLAYERS-1:0]                            score_inc,
    input  logic                                          clr_scores,
    output logic [6:0]                                    outs,
    output logic [PLAYERS*DIGITS-1:0]                     en,
    output logic                                          game_over,
    output logic [((PLAYERS > 1) ? $clog2(PLAYERS) : 1)-1:0] winner
);

    localparam int N   = PLAYERS * DIGITS;
    localparam int SW  = 4 * DIGITS;
    localparam int WW  = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BCW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    function automatic logic [SW-1:0] to_bcd(input int v);
        logic [SW-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_SCORE);
    localparam logic [SW-1:0] MAX_BCD = {DIGITS{4'h9}};

    // +1 with decimal carry ripple; holds at all nines instead of wrapping
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        logic c;
        r = s;
        c = 1'b1;
        if (s != MAX_BCD) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (c) begin
                    if (r[4*d +: 4] == 4'd9) begin
                        r[4*d +: 4] = 4'd0;
                    end else begin
                        r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [SW-1:0]  score [PLAYERS];
    logic           win_det;
    logic [WW-1:0]  win_idx;
    logic [BCW-1:0] blink_cnt;
    logic           blink_on;
    logic [IW-1:0]  idx;
    logic [DCW-1:0] dwell_cnt;
    logic [3:0]     dig;
    logic [WW-1:0]  sel_p;
    logic           lz;
    logic           blink_blank;
    logic [6:0]     seg_p0;
    logic [N-1:0]   en_p0;

    always_ff @(posedge clkouts) begin
        if (!resetb || clr_scores) begin
            for (int p = 0; p < PLAYERS; p++) score[p] <= '0;
        end else if (!game_over) begin
            for (int p = 0; p < PLAYERS; p++)
                if (score_inc[p]) score[p] <= bcd_inc(score[p]);
        end
    end

    // descending scan so the lowest index at WIN_SCORE wins ties
    always_comb begin
        win_det = 1'b0;
        win_idx = '0;
        for (int p = PLAYERS - 1; p >= 0; p--) begin
            if (score[p] == WIN_BCD) begin
                win_det = 1'b1;
                win_idx = WW'(p);
            end
        end
    end

    always_ff @(posedge clkouts) begin
        if (!resetb || clr_scores) begin
            game_over <= 1'b0;
            winner    <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (!game_over) begin
            if (win_det) begin
                game_over <= 1'b1;
                winner    <= win_idx;
            end
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BCW'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BCW'(1);
        end
    end

    // p0: digit select, leading-zero / blink blanking and decode for the current idx
    always_comb begin
        dig   = 4'd0;
        sel_p = '0;
        lz    = 1'b0;
        en_p0 = '1;
        for (int p = 0; p < PLAYERS; p++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (idx == IW'(p * DIGITS + d)) begin
                    sel_p = WW'(p);
                    dig   = score[p][4*(DIGITS-1-d) +: 4];
                    en_p0[N-1-(p*DIGITS+d)] = 1'b0;
                    lz = (BLANK_LZ != 0) && (d < DIGITS - 1);
                    for (int h = 0; h <= d; h++)
                        if (score[p][4*(DIGITS-1-h) +: 4] != 4'd0) lz = 1'b0;
                end
            end
        end
        blink_blank = game_over && !blink_on && (sel_p == winner);
        seg_p0      = (lz || blink_blank) ? 7'h7F : seg7(dig);
    end

    // p1: outs and en registered together so they never disagree
    always_ff @(posedge clkouts) begin
        if (!resetb) begin
            outs      <= 7'h7F;
            en        <= '1;
            idx       <= '0;
            dwell_cnt <= '0;
        end else begin
            outs <= seg_p0;
            en   <= en_p0;
            if (dwell_cnt == DCW'(DWELL - 1)) begin
                dwell_cnt <= '0;
                idx       <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
            end else begin
                dwell_cnt <= dwell_cnt + DCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_scoreboard_scan_driver.sv
// Directed bench for scoreboard_scan_driver: a 2x2-digit instance with fast blink
// and a 2x3-digit instance with DWELL=3 for saturation and mid-dwell reset.
module tb_scoreboard_scan_driver;

    logic       clk;
    logic       rstb_a, clr_a, rstb_b, clr_b;
    logic [1:0] inc_a, inc_b;
    logic [6:0] outs_a, outs_b;
    logic [3:0] en_a;
    logic [5:0] en_b;
    logic       go_a, go_b;
    logic [0:0] win_a, win_b;

    int checks = 0;
    int errors = 0;

    scoreboard_scan_driver #(.PLAYERS(2), .DIGITS(2), .WIN_SCORE(11), .DWELL(1),
                             .BLINK_CYCLES(4), .BLANK_LZ(1)) dut_a (
        .clkouts(clk), .resetb(rstb_a), .score_inc(inc_a), .clr_scores(clr_a),
        .outs(outs_a), .en(en_a), .game_over(go_a), .winner(win_a));

    scoreboard_scan_driver #(.PLAYERS(2), .DIGITS(3), .WIN_SCORE(999), .DWELL(3),
                             .BLINK_CYCLES(256), .BLANK_LZ(1)) dut_b (
        .clkouts(clk), .resetb(rstb_b), .score_inc(inc_b), .clr_scores(clr_b),
        .outs(outs_b), .en(en_b), .game_over(go_b), .winner(win_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       rstb;
        logic [1:0] inc;
        logic       clr;
        logic [3:0] en;
        logic [6:0] outs;
        logic       go;
        logic       win;
    } vec_t;

    vec_t tbl[19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // sync to P0 MS digit of dut_a, then check one full 4-digit scan
    task automatic check_scan(input string nm, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] ex [4];
        int n;
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        n = 0;
        tick();
        while (en_a !== 4'b0111 && n < 8) begin
            tick();
            n++;
        end
        chk({nm, "_sync"}, 32'(en_a), 32'(4'b0111));
        for (int k = 0; k < 4; k++) begin
            chk({nm, "_en"}, 32'(en_a), 32'(4'b1111 ^ (4'b1000 >> k)));
            chk({nm, "_outs"}, 32'(outs_a), 32'(ex[k]));
            if (k < 3) tick();
        end
    endtask

    initial begin
        logic [3:0] prev_en;
        logic [5:0] e_b;
        logic [6:0] exp_o;
        int n;
        bit p0, on;

        rstb_a = 1'b0; inc_a = 2'b00; clr_a = 1'b0;
        rstb_b = 1'b0; inc_b = 2'b00; clr_b = 1'b0;

        // rstb, inc, clr, en, outs, game_over, winner
        tbl[0]  = '{1'b0, 2'b00, 1'b0, 4'b1111, 7'h7F, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 2'b00, 1'b0, 4'b1111, 7'h7F, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'b00, 1'b0, 4'b0111, 7'h7F, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 2'b00, 1'b0, 4'b1011, 7'h01, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 2'b00, 1'b0, 4'b1101, 7'h7F, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 2'b00, 1'b0, 4'b1110, 7'h01, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 2'b00, 1'b0, 4'b0111, 7'h7F, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 2'b00, 1'b0, 4'b1011, 7'h01, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 2'b00, 1'b0, 4'b1111, 7'h7F, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 2'b00, 1'b0, 4'b0111, 7'h7F, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 2'b01, 1'b0, 4'b1011, 7'h01, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 2'b00, 1'b0, 4'b1101, 7'h7F, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 2'b00, 1'b0, 4'b1110, 7'h01, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 2'b00, 1'b0, 4'b0111, 7'h7F, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 2'b00, 1'b0, 4'b1011, 7'h4F, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 2'b01, 1'b1, 4'b1101, 7'h7F, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 2'b00, 1'b0, 4'b1110, 7'h01, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 2'b00, 1'b0, 4'b0111, 7'h7F, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 2'b00, 1'b0, 4'b1011, 7'h01, 1'b0, 1'b0};

        for (int i = 0; i < 19; i++) begin
            rstb_a = tbl[i].rstb;
            inc_a  = tbl[i].inc;
            clr_a  = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d_en", i),   32'(en_a),   32'(tbl[i].en));
            chk($sformatf("vec%0d_outs", i), 32'(outs_a), 32'(tbl[i].outs));
            chk($sformatf("vec%0d_go", i),   32'(go_a),   32'(tbl[i].go));
            chk($sformatf("vec%0d_win", i),  32'(win_a),  32'(tbl[i].win));
        end
        inc_a = 2'b00; clr_a = 1'b0;

        // nine pulses to P0, then the tenth carries into the MS digit
        inc_a = 2'b01;
        repeat (9) tick();
        inc_a = 2'b00;
        check_scan("p0_nine", 7'h7F, 7'h04, 7'h7F, 7'h01);
        inc_a = 2'b01;
        tick();
        inc_a = 2'b00;
        check_scan("p0_ten", 7'h4F, 7'h01, 7'h7F, 7'h01);

        inc_a = 2'b10;
        repeat (10) tick();
        inc_a = 2'b00;
        check_scan("p1_ten", 7'h4F, 7'h01, 7'h4F, 7'h01);
        chk("go_before_win", 32'(go_a), 32'(1'b0));

        // simultaneous reach of 11: game_over one cycle later, lowest index wins
        inc_a = 2'b11;
        tick();
        inc_a = 2'b00;
        chk("go_latency", 32'(go_a), 32'(1'b0));
        tick();
        chk("go_rise", 32'(go_a), 32'(1'b1));
        chk("winner_tie", 32'(win_a), 32'(1'b0));

        // pulses now ignored; P0 lit 4 samples, blank 4 samples; P1 always lit
        inc_a = 2'b11;
        for (int j = 1; j <= 32; j++) begin
            tick();
            p0 = (en_a[3] == 1'b0) || (en_a[2] == 1'b0);
            on = (((j - 1) / 4) % 2) == 0;
            exp_o = p0 ? (on ? 7'h4F : 7'h7F) : 7'h4F;
            chk($sformatf("blink%0d", j), 32'(outs_a), 32'(exp_o));
        end
        inc_a = 2'b00;
        chk("go_hold", 32'(go_a), 32'(1'b1));
        chk("winner_hold", 32'(win_a), 32'(1'b0));

        // clear beats a same-cycle point; scan keeps rotating
        prev_en = en_a;
        clr_a = 1'b1;
        inc_a = 2'b10;
        tick();
        clr_a = 1'b0;
        inc_a = 2'b00;
        chk("clr_scan_cont", 32'(en_a), 32'({prev_en[0], prev_en[3:1]}));
        chk("clr_go", 32'(go_a), 32'(1'b0));
        chk("clr_winner", 32'(win_a), 32'(1'b0));
        check_scan("after_clr", 7'h7F, 7'h01, 7'h7F, 7'h01);

        // dut_b: DWELL=3, three digits per player
        tick();
        chk("b_rst_en", 32'(en_b), 32'(6'h3F));
        chk("b_rst_outs", 32'(outs_b), 32'(7'h7F));
        chk("b_rst_go", 32'(go_b), 32'(1'b0));
        rstb_b = 1'b1;
        for (int j = 0; j < 9; j++) begin
            tick();
            chk($sformatf("b_dwell%0d_en", j), 32'(en_b), 32'(6'h3F ^ (6'h20 >> (j / 3))));
            chk($sformatf("b_dwell%0d_outs", j), 32'(outs_b), 32'((j / 3 == 2) ? 7'h01 : 7'h7F));
        end

        inc_b = 2'b10;
        repeat (999) tick();
        chk("b_go_latency", 32'(go_b), 32'(1'b0));
        tick();
        chk("b_go_rise", 32'(go_b), 32'(1'b1));
        chk("b_winner", 32'(win_b), 32'(1'b1));
        repeat (3) tick();
        inc_b = 2'b00;
        for (int j = 0; j < 18; j++) begin
            tick();
            if (en_b[5] == 1'b0 || en_b[4] == 1'b0) exp_o = 7'h7F;
            else if (en_b[3] == 1'b0)               exp_o = 7'h01;
            else                                    exp_o = 7'h04;
            chk($sformatf("b_sat%0d", j), 32'(outs_b), 32'(exp_o));
        end

        // reset asserted in the middle of a dwell
        e_b = en_b;
        n = 0;
        while (en_b === e_b && n < 6) begin
            tick();
            n++;
        end
        chk("b_dwell_edge", 32'(en_b != e_b), 32'(1'b1));
        tick();
        rstb_b = 1'b0;
        tick();
        chk("b_midrst_en", 32'(en_b), 32'(6'h3F));
        chk("b_midrst_outs", 32'(outs_b), 32'(7'h7F));
        chk("b_midrst_go", 32'(go_b), 32'(1'b0));
        chk("b_midrst_win", 32'(win_b), 32'(1'b0));
        rstb_b = 1'b1;
        tick();
        chk("b_restart_en", 32'(en_b), 32'(6'b011111));
        chk("b_restart_outs", 32'(outs_b), 32'(7'h7F));
        tick();
        chk("b_restart_hold", 32'(en_b), 32'(6'b011111));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
